rs_check: RTL and testbench

- Byte-serial Reed-Solomon syndrome checker for the Twofish key-schedule S-vector. It is the receive/check end of the RS(12,8) code over GF(2^8).
- Consumes 8 key-material bytes followed by the 4 received S bytes. Recomputes S = RS·m and reports the computed S, the syndrome (computed XOR received) and a pass flag.
- Used when S-words arrive from an external key store, so corrupted or mismatched key material is caught before the g-function S-boxes are loaded.
- A full key is processed as KEY_GROUPS consecutive frames; each frame yields one result tagged with its group index.

---
 rtl/rs_check.sv | 154 +++++++++++++++
 tb/tb_rs_check.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rs_check.sv
// Byte-serial RS(12,8) syndrome checker for Twofish key-schedule S-words.
// Accumulates RS*m over 8 key bytes, compares with 4 received bytes, holds the result until popped.
//
// state   | meaning
// ACCUM   | taking m0..m7, folding each byte into the four S accumulators
// COMPARE | taking r0..r3, the received S bytes
// HOLD    | result presented on out_*, waiting for out_ready
module rs_check #(
  parameter int KEY_GROUPS = 2,
  localparam int GW = (KEY_GROUPS > 1) ? $clog2(KEY_GROUPS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_s,
  output logic [31:0]   out_syn,
  output logic          out_ok,
  output logic [GW-1:0] out_group
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    COMPARE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     count_q, count_d;
  logic [31:0]    acc_q, acc_d;
  logic [31:0]    rx_q, rx_d;
  logic           out_valid_q, out_valid_d;
  logic [31:0]    out_s_q, out_s_d;
  logic [31:0]    out_syn_q, out_syn_d;
  logic           out_ok_q, out_ok_d;
  logic [GW-1:0]  group_q, group_d;
  logic           xfer;
  logic [31:0]    col;
  logic [31:0]    rx_full;

  // GF(2^8) multiply modulo x^8+x^6+x^3+x^2+1; bit 8 of 0x14D drops out of the 8-bit shift.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h4D) : (x << 1);
    end
    return p;
  endfunction

  // One RS matrix column packed as {row3, row2, row1, row0}.
  function automatic logic [31:0] rs_col(input logic [2:0] c);
    logic [31:0] v;
    case (c)
      3'd0:    v = 32'hA4_02_A4_01;
      3'd1:    v = 32'h55_A1_56_A4;
      3'd2:    v = 32'h87_FC_82_55;
      3'd3:    v = 32'h5A_C1_F3_87;
      3'd4:    v = 32'h58_47_1E_5A;
      3'd5:    v = 32'hDB_AE_C6_58;
      3'd6:    v = 32'h9E_3D_68_DB;
      default: v = 32'h03_19_E5_9E;
    endcase
    return v;
  endfunction

  assign in_ready = (state_q != HOLD);
  assign xfer     = in_valid && in_ready;
  assign col      = rs_col(count_q[2:0]);
  assign rx_full  = {in_data, rx_q[31:8]};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    rx_d        = rx_q;
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_syn_d   = out_syn_q;
    out_ok_d    = out_ok_q;
    group_d     = group_q;

    case (state_q)
      ACCUM: begin
        if (xfer) begin
          for (int j = 0; j < 4; j++) begin
            acc_d[8*j +: 8] = acc_q[8*j +: 8] ^ gf_mul(col[8*j +: 8], in_data);
          end
          count_d = count_q + 4'd1;
          if (count_q == 4'd7) state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (xfer) begin
          rx_d    = rx_full;
          count_d = count_q + 4'd1;
          if (count_q == 4'd11) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_s_d     = acc_q;
            out_syn_d   = acc_q ^ rx_full;
            out_ok_d    = ~|(acc_q ^ rx_full);
          end
        end
      end
      default: begin
        if (out_ready) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
          acc_d       = 32'h0;
          count_d     = 4'd0;
          group_d     = (group_q == GW'(KEY_GROUPS - 1)) ? '0 : group_q + GW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      count_q     <= 4'd0;
      acc_q       <= 32'h0;
      rx_q        <= 32'h0;
      out_valid_q <= 1'b0;
      out_s_q     <= 32'h0;
      out_syn_q   <= 32'h0;
      out_ok_q    <= 1'b0;
      group_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      rx_q        <= rx_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_syn_q   <= out_syn_d;
      out_ok_q    <= out_ok_d;
      group_q     <= group_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_syn   = out_syn_q;
  assign out_ok    = out_ok_q;
  assign out_group = group_q;

endmodule

// File: tb/tb_rs_check.sv
// Directed plus randomized bench for rs_check against a polynomial-arithmetic RS reference.
module tb_rs_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_s;
  logic [31:0] out_syn;
  logic        out_ok;
  logic [0:0]  out_group;

  int checks = 0;
  int errors = 0;
  int exp_group = 0;

  localparam logic [7:0] RSM [4][8] = '{
    '{8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E},
    '{8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5},
    '{8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19},
    '{8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03}
  };

  rs_check #(.KEY_GROUPS(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_syn(out_syn), .out_ok(out_ok), .out_group(out_group)
  );

  always #5 clk = ~clk;

  // Carry-less product then long division by 0x14D.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h014D << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] model_s(input logic [63:0] m);
    logic [31:0] s;
    s = 32'h0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 8; k++)
        s[8*j +: 8] = s[8*j +: 8] ^ gmul(RSM[j][k], m[8*k +: 8]);
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 50 && !in_ready; n++) tick();
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout observed=0 expected=1");
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic feed(input logic [63:0] m, input logic [31:0] r, input int nbytes, input bit gaps);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b = (i < 8) ? m[8*i +: 8] : r[8*(i-8) +: 8];
      if (gaps) repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
      send_byte(b);
    end
  endtask

  task automatic run_frame(input logic [63:0] m, input logic [31:0] r, input bit gaps, input int stall);
    logic [31:0] es;
    es = model_s(m);
    feed(m, r, 12, gaps);
    check("out_valid_latency", 32'(out_valid), 32'd1);
    check("out_s", out_s, es);
    check("out_syn", out_syn, es ^ r);
    check("out_ok", 32'(out_ok), 32'((es ^ r) == 32'h0));
    check("out_group", 32'(out_group), 32'(exp_group));
    check("in_ready_hold", 32'(in_ready), 32'd0);
    for (int c = 0; c < stall; c++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      tick();
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_syn", out_syn, es ^ r);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("pop_out_valid", 32'(out_valid), 32'd0);
    check("pop_in_ready", 32'(in_ready), 32'd1);
    exp_group = (exp_group + 1) % 2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_group = 0;
  endtask

  initial begin
    logic [63:0] m;
    logic [31:0] r;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    do_reset();

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_s", out_s, 32'h0);
    check("rst_out_syn", out_syn, 32'h0);
    check("rst_out_ok", 32'(out_ok), 32'd0);
    check("rst_out_group", 32'(out_group), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    run_frame(64'h0, 32'h0, 1'b0, 0);
    check("zero_ref", model_s(64'h0), 32'h0);
    run_frame(64'h01, 32'hA402A401, 1'b0, 0);
    run_frame(64'h01 << 56, 32'h0, 1'b0, 0);
    run_frame(64'h02 << 8, 32'hAA0FAC05, 1'b0, 0);
    run_frame((64'h01 << 56) | 64'h01, 32'hA71B419F, 1'b0, 0);

    // Backpressure with in_valid held high, then a frame whose result proves nothing leaked in.
    run_frame(64'h0123456789ABCDEF, 32'h12345678, 1'b0, 5);
    run_frame(64'h01, 32'hA402A401, 1'b0, 0);

    for (int t = 0; t < 8; t++) begin
      m = {$urandom, $urandom};
      r = (t % 2 == 0) ? model_s(m) : $urandom;
      run_frame(m, r, 1'b0, 0);
      run_frame(m, r, 1'b1, $urandom_range(0, 2));
    end

    // Abort mid-frame, then abort a pending result in HOLD.
    feed(64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 6, 1'b0);
    do_reset();
    check("abort_out_valid", 32'(out_valid), 32'd0);
    run_frame(64'h01, 32'hA402A401, 1'b0, 0);
    feed(64'h55, 32'h0, 12, 1'b0);
    check("hold_before_rst", 32'(out_valid), 32'd1);
    do_reset();
    check("hold_abort_valid", 32'(out_valid), 32'd0);
    check("hold_abort_ready", 32'(in_ready), 32'd1);
    run_frame(64'h01, 32'hA402A401, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
